// File: rtl/iq_demod_pkg.sv
// iq_demod_pkg: scheduler state encoding and default window geometry
package iq_demod_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SEARCH = 2'd2,
    S_TRACK  = 2'd3
  } sched_state_e;
  localparam int DECIM_DEF    = 5;
  localparam int TAPS_DEF     = 20;
  localparam int SYM_LEN_DEF  = 16;
  localparam int MAX_MISS_DEF = 3;
endpackage

// File: rtl/iq_decim_counter.sv
// iq_decim_counter: sample decimation phase and qualifying-sample strobe
module iq_decim_counter
  import iq_demod_pkg::*;
#(
  parameter int DECIM = DECIM_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_run,
  input  logic       i_sample_valid,
  output logic [2:0] o_phase,
  output logic       o_qual
);
  logic [2:0] r_phase;
  logic       w_last;
  assign w_last = r_phase == 3'(DECIM - 1);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_phase <= '0;
    else if (i_clr) r_phase <= '0;
    else if (i_run && i_sample_valid) r_phase <= w_last ? '0 : r_phase + 3'd1;
  end
  assign o_phase = r_phase;
  assign o_qual  = i_sample_valid & w_last;
endmodule

// File: rtl/iq_window_sched.sv
// iq_window_sched: decimated window shifting, fill tracking and SEARCH/TRACK correlator scheduling
module iq_window_sched
  import iq_demod_pkg::*;
#(
  parameter int DECIM    = DECIM_DEF,
  parameter int TAPS     = TAPS_DEF,
  parameter int SYM_LEN  = SYM_LEN_DEF,
  parameter int MAX_MISS = MAX_MISS_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_sample_valid,
  input  logic                        i_corr_ack,
  input  logic                        i_corr_hit,
  input  logic                        i_err_clr,
  output logic                        o_shift_en,
  output logic [2:0]                  o_decim_phase,
  output logic [$clog2(TAPS+1)-1:0]   o_fill_level,
  output logic                        o_corr_req,
  output logic                        o_locked,
  output logic                        o_sym_strobe,
  output logic                        o_overrun_err,
  output logic [1:0]                  o_state
);
  localparam int FW = $clog2(TAPS + 1);
  localparam int SW = $clog2(SYM_LEN);
  localparam int MW = $clog2(MAX_MISS + 1);
  sched_state_e r_state, w_next;
  logic [FW-1:0] r_fill;
  logic [SW-1:0] r_sym_cnt;
  logic [MW-1:0] r_miss;
  logic r_req, r_sym, r_err;
  logic w_run, w_qual, w_busy, w_ack, w_shift, w_lost, w_sched, w_fill_done, w_last_miss;
  iq_decim_counter #(.DECIM(DECIM)) u_decim (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_clr(~i_enable),
    .i_run(w_run),
    .i_sample_valid(i_sample_valid),
    .o_phase(o_decim_phase),
    .o_qual(w_qual)
  );
  assign w_run       = r_state != S_IDLE;
  // an ack in the same cycle releases the window, so the shift is not lost
  assign w_busy      = r_req & ~i_corr_ack;
  assign w_ack       = r_req & i_corr_ack;
  assign w_shift     = w_qual & w_run & ~w_busy;
  assign w_lost      = w_qual & w_run & w_busy;
  assign w_fill_done = r_state == S_FILL && r_fill == FW'(TAPS - 1);
  assign w_sched     = w_shift & (w_fill_done | r_state == S_SEARCH |
                       (r_state == S_TRACK && r_sym_cnt == SW'(SYM_LEN - 1)));
  assign w_last_miss = r_state == S_TRACK && w_ack && !i_corr_hit && r_miss == MW'(MAX_MISS - 1);
  always_comb begin
    w_next = r_state;
    if (!i_enable) w_next = S_IDLE;
    else if (r_state == S_IDLE) w_next = S_FILL;
    else if (w_fill_done && w_shift) w_next = S_SEARCH;
    else if (r_state == S_SEARCH && w_ack && i_corr_hit) w_next = S_TRACK;
    else if (w_last_miss) w_next = S_SEARCH;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill    <= '0;
      r_sym_cnt <= '0;
      r_miss    <= '0;
      r_req     <= 1'b0;
      r_sym     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err     <= w_lost | (r_err & ~i_err_clr);
      r_req     <= i_enable & (w_sched | (r_req & ~i_corr_ack));
      r_sym     <= i_enable & (r_state == S_TRACK) & w_ack & i_corr_hit;
      r_fill    <= !i_enable ? '0 : (w_shift && r_fill != FW'(TAPS)) ? r_fill + 1'b1 : r_fill;
      r_sym_cnt <= (!i_enable || r_state != S_TRACK) ? '0 :
                   !w_shift ? r_sym_cnt : (r_sym_cnt == SW'(SYM_LEN - 1)) ? '0 : r_sym_cnt + 1'b1;
      r_miss    <= (!i_enable || r_state != S_TRACK || (w_ack && i_corr_hit)) ? '0 :
                   w_ack ? r_miss + 1'b1 : r_miss;
    end
  end
  assign o_shift_en    = w_shift;
  assign o_fill_level  = r_fill;
  assign o_corr_req    = r_req;
  assign o_locked      = r_state == S_TRACK;
  assign o_sym_strobe  = r_sym;
  assign o_overrun_err = r_err;
  assign o_state       = r_state;
endmodule
